// File: rtl/reg_writeback_ctrl.sv
// Register file writeback arbiter: ALU has strict priority over buffered LSU results.
// Also tracks loads still outstanding for R0..NUM_GPR-1 and drops writes to read-only regs.
module reg_writeback_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int NUM_GPR        = 13,
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alu_wb_valid,
    input  logic [ADDR_W-1:0]                 alu_wb_addr,
    input  logic [DATA_W-1:0]                 alu_wb_data,
    input  logic                              lsu_wb_valid,
    output logic                              lsu_wb_ready,
    input  logic [ADDR_W-1:0]                 lsu_wb_addr,
    input  logic [DATA_W-1:0]                 lsu_wb_data,
    input  logic                              issue_load_valid,
    input  logic [ADDR_W-1:0]                 issue_load_addr,
    output logic [NUM_GPR-1:0]                pending_mask,
    output logic                              write_enable,
    output logic [ADDR_W-1:0]                 write_addr,
    output logic [DATA_W-1:0]                 write_data,
    output logic                              ro_write_err,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(LSU_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W:0] GPR_LIM = (ADDR_W+1)'(NUM_GPR);
    localparam logic [CW-1:0]   DEPTH_C = CW'(LSU_FIFO_DEPTH);

    logic [ADDR_W-1:0]  r_fifo_addr [LSU_FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [LSU_FIFO_DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err;
    logic [NUM_GPR-1:0] r_pending;

    logic               w_alu_ok;
    logic               w_alu_ro;
    logic               w_lsu_addr_ok;
    logic               w_lsu_acc;
    logic               w_lsu_ro;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;
    logic [NUM_GPR-1:0] w_pend_nxt;

    assign w_alu_ok      = alu_wb_valid && ({1'b0, alu_wb_addr} < GPR_LIM);
    assign w_alu_ro      = alu_wb_valid && !w_alu_ok;
    assign w_lsu_addr_ok = {1'b0, lsu_wb_addr} < GPR_LIM;
    assign w_lsu_acc     = lsu_wb_valid && lsu_wb_ready;
    assign w_lsu_ro      = w_lsu_acc && !w_lsu_addr_ok;
    assign w_push        = w_lsu_acc && w_lsu_addr_ok;
    assign w_pop         = !w_alu_ok && (r_count != '0);
    assign w_head_addr   = r_fifo_addr[r_rd_ptr];
    assign w_head_data   = r_fifo_data[r_rd_ptr];

    // Ready reflects occupancy before this edge's pop, so a full FIFO never takes a beat.
    assign lsu_wb_ready  = !reset && (r_count < DEPTH_C);

    // Issue is applied after the clear so a same-edge set wins.
    always_comb begin
        w_pend_nxt = r_pending;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (w_pop && (w_head_addr == ADDR_W'(i)))
                w_pend_nxt[i] = 1'b0;
        end
        for (int i = 0; i < NUM_GPR; i++) begin
            if (issue_load_valid && (issue_load_addr == ADDR_W'(i)))
                w_pend_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= lsu_wb_addr;
            r_fifo_data[r_wr_ptr] <= lsu_wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_pending <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            r_we <= w_alu_ok || w_pop;
            if (w_alu_ok) begin
                r_waddr <= alu_wb_addr;
                r_wdata <= alu_wb_data;
            end else if (w_pop) begin
                r_waddr <= w_head_addr;
                r_wdata <= w_head_data;
            end
            r_err     <= w_alu_ro || w_lsu_ro;
            r_pending <= w_pend_nxt;
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_data   = r_wdata;
    assign ro_write_err = r_err;
    assign pending_mask = r_pending;
    assign fifo_count   = r_count;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: queue-based reference model plus directed scenarios.
// Random phases vary ALU load to exercise FIFO fill, starvation and async reset.
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_addr;
    logic [7:0]  alu_wb_data;
    logic        lsu_wb_valid;
    logic        lsu_wb_ready;
    logic [3:0]  lsu_wb_addr;
    logic [7:0]  lsu_wb_data;
    logic        issue_load_valid;
    logic [3:0]  issue_load_addr;
    logic [12:0] pending_mask;
    logic        write_enable;
    logic [3:0]  write_addr;
    logic [7:0]  write_data;
    logic        ro_write_err;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    reg_writeback_ctrl dut (
        .clk(clk), .reset(reset),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
        .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .issue_load_valid(issue_load_valid),
        .issue_load_addr(issue_load_addr),
        .pending_mask(pending_mask), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data),
        .ro_write_err(ro_write_err), .fifo_count(fifo_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: the FIFO is a plain queue of {addr,data}.
    logic [11:0] q[$];
    logic        m_we, m_err, m_acc, m_alu_ok;
    logic [3:0]  m_addr;
    logic [7:0]  m_data;
    logic [12:0] m_mask;
    logic [11:0] m_h;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_we = 0; m_err = 0; m_addr = 0; m_data = 0; m_mask = 0;
        end else begin
            m_acc    = lsu_wb_valid && (q.size() < 4);
            m_alu_ok = alu_wb_valid && (alu_wb_addr < 13);
            m_err    = (alu_wb_valid && !m_alu_ok)
                     || (m_acc && lsu_wb_addr >= 13);
            if (m_alu_ok) begin
                m_we = 1; m_addr = alu_wb_addr; m_data = alu_wb_data;
            end else if (q.size() > 0) begin
                m_h = q.pop_front();
                m_we = 1; m_addr = m_h[11:8]; m_data = m_h[7:0];
                m_mask[m_h[11:8]] = 1'b0;
            end else begin
                m_we = 0;
            end
            if (m_acc && lsu_wb_addr < 13)
                q.push_back({lsu_wb_addr, lsu_wb_data});
            if (issue_load_valid && issue_load_addr < 13)
                m_mask[issue_load_addr] = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && !reset) begin
            chk("m_we",    32'(write_enable), 32'(m_we));
            if (m_we) begin
                chk("m_addr", 32'(write_addr), 32'(m_addr));
                chk("m_data", 32'(write_data), 32'(m_data));
            end
            chk("m_err",   32'(ro_write_err), 32'(m_err));
            chk("m_mask",  32'(pending_mask), 32'(m_mask));
            chk("m_count", 32'(fifo_count),   32'(q.size()));
            chk("m_ready", 32'(lsu_wb_ready), 32'(q.size() < 4));
        end
    end

    task automatic drv(input logic av, input logic [3:0] aa,
                       input logic [7:0] ad, input logic lv,
                       input logic [3:0] la, input logic [7:0] ld,
                       input logic iv, input logic [3:0] ia);
        @(negedge clk);
        alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
        lsu_wb_valid = lv; lsu_wb_addr = la; lsu_wb_data = ld;
        issue_load_valid = iv; issue_load_addr = ia;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] v;
    int pct;

    initial begin
        reset = 1;
        alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
        issue_load_valid = 0; issue_load_addr = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_we",    32'(write_enable), 0);
        chk("rst_err",   32'(ro_write_err), 0);
        chk("rst_mask",  32'(pending_mask), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(lsu_wb_ready), 0);
        @(negedge clk);
        reset = 0;
        chk_en = 1;

        // ALU single write
        drv(1, 3, 8'h5A, 0, 0, 0, 0, 0); step();
        chk("alu_we",   32'(write_enable), 1);
        chk("alu_addr", 32'(write_addr), 3);
        chk("alu_data", 32'(write_data), 32'h5A);
        idle(); step();
        chk("alu_we0",  32'(write_enable), 0);

        // ALU hogs the port while LSU fills the FIFO
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h11 * (i + 1));
            drv(1, 0, 8'(i), i < 4, 4'(i + 1), v, 0, 0); step();
            if (i == 3) begin
                chk("full_cnt",   32'(fifo_count), 4);
                chk("full_ready", 32'(lsu_wb_ready), 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            v = 8'(8'h11 * (k + 1));
            idle(); step();
            chk("drain_we",   32'(write_enable), 1);
            chk("drain_addr", 32'(write_addr), 32'(k + 1));
            chk("drain_data", 32'(write_data), 32'(v));
            chk("drain_cnt",  32'(fifo_count), 32'(3 - k));
        end

        // Scoreboard on R7
        drv(0, 0, 0, 0, 0, 0, 1, 7); step();
        chk("pend7_set", 32'(pending_mask[7]), 1);
        idle(); step(); idle(); step();
        chk("pend7_hold", 32'(pending_mask[7]), 1);
        drv(0, 0, 0, 1, 7, 8'h99, 0, 0); step();
        chk("ld7_we0", 32'(write_enable), 0);
        chk("ld7_pend", 32'(pending_mask[7]), 1);
        idle(); step();
        chk("ld7_we",   32'(write_enable), 1);
        chk("ld7_addr", 32'(write_addr), 7);
        chk("ld7_data", 32'(write_data), 32'h99);
        chk("ld7_clr",  32'(pending_mask[7]), 0);

        // Read-only destination
        drv(1, 14, 8'hEE, 0, 0, 0, 0, 0); step();
        chk("ro_we",  32'(write_enable), 0);
        chk("ro_err", 32'(ro_write_err), 1);
        idle(); step();
        chk("ro_err0", 32'(ro_write_err), 0);

        // Set beats clear on the same edge
        drv(0, 0, 0, 1, 2, 8'h22, 1, 2); step();
        chk("p2_set", 32'(pending_mask[2]), 1);
        drv(0, 0, 0, 0, 0, 0, 1, 2); step();
        chk("p2_we",   32'(write_enable), 1);
        chk("p2_addr", 32'(write_addr), 2);
        chk("p2_keep", 32'(pending_mask[2]), 1);

        // Async reset with buffered entries and an in-flight write
        drv(1, 0, 1, 1, 5, 8'h55, 1, 3); step();
        drv(1, 0, 2, 1, 6, 8'h66, 0, 0); step();
        drv(1, 0, 3, 1, 8, 8'h88, 0, 0); step();
        chk("pre_cnt",  32'(fifo_count), 3);
        chk("pre_mask", 32'(pending_mask), 32'h0C);
        drv(1, 1, 8'h77, 0, 0, 0, 0, 0);
        #1 reset = 1;
        #1;
        chk("ar_cnt",   32'(fifo_count), 0);
        chk("ar_we",    32'(write_enable), 0);
        chk("ar_mask",  32'(pending_mask), 0);
        chk("ar_ready", 32'(lsu_wb_ready), 0);
        idle();
        reset = 0;

        // Randomized traffic in phases of differing ALU pressure
        pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) pct = $urandom_range(0, 2) * 45 + 5;
            @(negedge clk);
            alu_wb_valid     = $urandom_range(0, 99) < pct;
            alu_wb_addr      = 4'($urandom_range(0, 15));
            alu_wb_data      = 8'($urandom);
            lsu_wb_valid     = $urandom_range(0, 1) == 1;
            lsu_wb_addr      = 4'($urandom_range(0, 15));
            lsu_wb_data      = 8'($urandom);
            issue_load_valid = $urandom_range(0, 2) == 0;
            issue_load_addr  = 4'($urandom_range(0, 15));
            if (n % 700 == 350) begin
                #3 reset = 1;
                @(negedge clk);
                reset = 0;
            end
        end
        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
